// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per clock, level enable/done handshake.
// Optional early termination on an exhausted multiplier: define SHIFT_ADD_EARLY_TERM_EN.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mul_en,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               multiply_done,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (mul_en) begin
          mcand_d = {{WIDTH{1'b0}}, a_in};
          mplr_d  = b_in;
          prod_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Dropping the request mid-run abandons the partial product without signalling done.
        if (!mul_en) begin
          state_d = IDLE;
        end
`ifdef SHIFT_ADD_EARLY_TERM_EN
        else if (mplr_q == '0) begin
          state_d = DONE;
        end
`endif
        else begin
          if (mplr_q[0]) prod_d = prod_q + mcand_q;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (!mul_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with state_q.
  assign done_d = (state_d == DONE);
  assign busy_d = (state_d == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign multiply_done = done_q;
  assign busy          = busy_q;
  assign product       = prod_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (WIDTH=8); latency expectations follow SHIFT_ADD_EARLY_TERM_EN.
module tb_shift_add_multiplier;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               mul_en;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               multiply_done;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .mul_en        (mul_en),
    .a_in          (a_in),
    .b_in          (b_in),
    .multiply_done (multiply_done),
    .product       (product),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Edges after the load edge until done is first seen high.
  function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef SHIFT_ADD_EARLY_TERM_EN
    int msb;
    if (b == '0) return 1;
    msb = 0;
    for (int k = 0; k < WIDTH; k++) if (b[k]) msb = k;
    return (msb + 2 < WIDTH) ? msb + 2 : WIDTH;
`else
    return WIDTH;
`endif
  endfunction

  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a_in = ~a_in;
        b_in = b_in ^ 8'hA5;
      end
      if (busy) bcnt++;
      if (multiply_done) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    a_in   = a;
    b_in   = b;
    mul_en = 1'b1;
  endtask

  task automatic drop_op(input string tag, input logic [2*WIDTH-1:0] exp_p);
    mul_en = 1'b0;
    @(negedge clk);
    check({tag, "_done_low"}, multiply_done, 0);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_prod_hold"}, product, exp_p);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2*WIDTH-1:0] exp_p);
    int lat, bc;
    start_op(a, b);
    wait_done(lat, bc);
    check({tag, "_lat"}, lat, exp_lat(b));
    check({tag, "_busy_cycles"}, bc, exp_lat(b));
    check({tag, "_prod"}, product, exp_p);
  endtask

  initial begin
    int bad, cnt, lat, bc;
    rst    = 1'b1;
    mul_en = 1'b0;
    a_in   = '0;
    b_in   = '0;
    repeat (2) @(negedge clk);
    check("rst_done", multiply_done, 0);
    check("rst_busy", busy, 0);
    check("rst_prod", product, 0);
    rst = 1'b0;

    // 1 + 5: full-scale operands, request held well past done.
    run_op("t1", 8'hFF, 8'hFF, 16'hFE01);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (multiply_done !== 1'b1 || busy !== 1'b0 || product !== 16'hFE01) bad++;
    end
    check("t5_held_bad_cycles", bad, 0);
    drop_op("t1", 16'hFE01);

    // 2: small operands, product held in IDLE.
    run_op("t2", 8'h0D, 8'h0B, 16'h008F);
    drop_op("t2", 16'h008F);
    a_in = 8'h77;
    b_in = 8'h99;
    repeat (3) @(negedge clk);
    check("t2_idle_prod", product, 16'h008F);

    // 3: abort mid-run, then a fresh operation.
    start_op(8'h12, 8'h34);
    repeat (3) @(negedge clk);
    check("t3_busy_mid", busy, 1);
    mul_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (multiply_done) cnt++;
    end
    check("t3_abort_done_cnt", cnt, 0);
    check("t3_abort_busy", busy, 0);
    run_op("t3b", 8'h03, 8'h05, 16'h000F);
    drop_op("t3b", 16'h000F);

    // 4: asynchronous reset mid-run with request still asserted.
    start_op(8'h21, 8'h47);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t4_rst_busy", busy, 0);
    check("t4_rst_done", multiply_done, 0);
    check("t4_rst_prod", product, 0);
    #2;
    rst = 1'b0;
    a_in = 8'h21;
    b_in = 8'h47;
    wait_done(lat, bc);
    check("t4_lat", lat, exp_lat(8'h47));
    check("t4_prod", product, 16'h0927);
    drop_op("t4", 16'h0927);

    // 6: operands where early termination changes latency only.
    run_op("t6a", 8'h5A, 8'h00, 16'h0000);
    drop_op("t6a", 16'h0000);
    run_op("t6b", 8'h10, 8'h01, 16'h0010);
    drop_op("t6b", 16'h0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
